// File: rtl/valve_peak_hold_rx.sv
// valve_peak_hold_rx: serial valve frame receiver with per-channel peak-and-hold drive; optional VALVE_HOLD_TIMEOUT_EN forces all valves off after TIMEOUT_CYCLES without a valid frame
module valve_peak_hold_rx #(
  parameter int CHANNELS       = 48,
  parameter int HV_CYCLES      = 20000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                line_sclk,
  input  logic                line_sen,
  input  logic                line_sdata,
  output logic [CHANNELS-1:0] valve_state,
  output logic [CHANNELS-1:0] signal_high_voltage,
  output logic [CHANNELS-1:0] signal_low_voltage,
  output logic                frame_err
);
  localparam int CW = $clog2(CHANNELS + 2);
  typedef enum logic [1:0] {OFF, KICK, HOLD} drv_t;
  logic [1:0] r_sclk_s, r_sen_s, r_sdata_s;
  logic r_sclk_d, r_sen_d;
  logic [CW-1:0] r_cnt;
  logic [CHANNELS-1:0] r_shift;
  logic w_sclk_rise, w_sen_rise, w_sen_fall, w_din, w_commit, w_expire;
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_sen_rise  = r_sen_s[1] & ~r_sen_d;
  assign w_sen_fall  = ~r_sen_s[1] & r_sen_d;
  assign w_din       = ~r_sdata_s[1];
  assign w_commit    = w_sen_fall && r_cnt == CW'(CHANNELS);
  // two-flop synchronisers plus one delay stage for edge detection
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sclk_s  <= '0;
      r_sen_s   <= '0;
      r_sdata_s <= '0;
      r_sclk_d  <= 1'b0;
      r_sen_d   <= 1'b0;
    end else begin
      r_sclk_s  <= {r_sclk_s[0], line_sclk};
      r_sen_s   <= {r_sen_s[0], line_sen};
      r_sdata_s <= {r_sdata_s[0], line_sdata};
      r_sclk_d  <= r_sclk_s[1];
      r_sen_d   <= r_sen_s[1];
    end
  end
  // shift in active-low bits, bit k to channel k; shifting past CHANNELS drops extra bits
  always_ff @(posedge sys_clk) begin
    if (rst || w_sen_rise) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_sclk_rise && r_sen_s[1]) begin
      r_shift <= r_shift | (CHANNELS'(w_din) << r_cnt);
      r_cnt   <= (r_cnt == CW'(CHANNELS + 1)) ? r_cnt : r_cnt + 1'b1;
    end
  end
`ifdef VALVE_HOLD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to;
  assign w_expire = r_to == TW'(TIMEOUT_CYCLES - 1);
  // cycles since last valid commit, parked at the expiry value
  always_ff @(posedge sys_clk) begin
    if (rst || w_commit) r_to <= '0;
    else if (!w_expire) r_to <= r_to + 1'b1;
  end
`else
  assign w_expire = 1'b0;
`endif
  // commit complete frames, flag short or long ones
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      valve_state <= '0;
      frame_err   <= 1'b0;
    end else begin
      valve_state <= w_commit ? r_shift : w_expire ? '0 : valve_state;
      frame_err   <= w_sen_fall && !w_commit;
    end
  end
  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    drv_t r_st, w_nxt;
    logic [15:0] r_kc;
    logic r_hv, r_lv;
    // off wins; a fresh turn-on kicks; kick ends after HV_CYCLES
    always_comb begin
      w_nxt = !valve_state[g] ? OFF :
              r_st == OFF ? KICK :
              (r_st == KICK && r_kc == 16'(HV_CYCLES - 1)) ? HOLD : r_st;
    end
    // state, kick length counter and registered drive outputs
    always_ff @(posedge sys_clk) begin
      if (rst) begin
        r_st <= OFF;
        r_kc <= '0;
        r_hv <= 1'b0;
        r_lv <= 1'b0;
      end else begin
        r_st <= w_nxt;
        r_kc <= (r_st == KICK && w_nxt == KICK) ? r_kc + 1'b1 : '0;
        r_hv <= w_nxt == KICK;
        r_lv <= w_nxt == HOLD;
      end
    end
    assign signal_high_voltage[g] = r_hv;
    assign signal_low_voltage[g]  = r_lv;
  end
endmodule

// File: tb/tb_valve_peak_hold_rx.sv
// tb_valve_peak_hold_rx: scoreboard bench with random frames and a timing reference model of the drives
module tb_valve_peak_hold_rx;
  localparam int CH = 48, HV = 4, TO = 1000;
  logic sys_clk = 0, rst = 1, line_sclk = 0, line_sen = 0, line_sdata = 1;
  logic [CH-1:0] valve_state, hi, lo;
  logic frame_err;
  int checks = 0, failures = 0, n_err = 0;
  typedef struct {bit valid; bit lost; logic [CH-1:0] val;} exp_t;
  exp_t sb[$];
  logic [CH-1:0] model_vs = '0, vs_prev = '0;
  logic rst_prev = 1;
  longint cyc = 0, last_commit = 0;
  int run[CH];
  valve_peak_hold_rx #(.CHANNELS(CH), .HV_CYCLES(HV), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst(rst), .line_sclk(line_sclk), .line_sen(line_sen),
    .line_sdata(line_sdata), .valve_state(valve_state), .signal_high_voltage(hi),
    .signal_low_voltage(lo), .frame_err(frame_err)
  );
  always #25 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) if (frame_err) n_err <= n_err + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  // reference drive timing: a channel kicks for HV cycles after its state has been on, then holds
  always @(negedge sys_clk) begin
    logic [CH-1:0] eh, el;
    for (int i = 0; i < CH; i++) begin
      eh[i] = !rst_prev && vs_prev[i] && run[i] >= 1 && run[i] <= HV;
      el[i] = !rst_prev && vs_prev[i] && run[i] > HV;
    end
    chk("drive_high", hi, eh);
    chk("drive_low", lo, el);
    for (int i = 0; i < CH; i++) run[i] = valve_state[i] ? (run[i] > HV ? run[i] : run[i] + 1) : 0;
    vs_prev = valve_state;
    rst_prev = rst;
  end
  // monitor: each frame end yields a committed state and a frame_err pulse count
  initial forever begin
    int e0;
    exp_t e;
    @(negedge line_sen);
    e0 = n_err;
    repeat (8) @(negedge sys_clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame actual=frame required=none");
    end else begin
      e = sb.pop_front();
      if (e.valid) begin
        model_vs = e.val;
        last_commit = cyc;
      end else if (e.lost) model_vs = '0;
`ifdef VALVE_HOLD_TIMEOUT_EN
      else if (cyc - last_commit >= TO) model_vs = '0;
`endif
      chk("frame_state", valve_state, model_vs);
      chk("frame_err_pulses", 64'(n_err - e0), e.valid ? 64'd0 : 64'd1);
    end
  end
  task automatic send(input logic [CH-1:0] v, input int len, input int rst_at);
    exp_t e;
    e.valid = len == CH && rst_at < 0;
    e.lost = rst_at >= 0;
    e.val = v;
    sb.push_back(e);
    line_sen = 1;
    #500;
    for (int k = 0; k < len; k++) begin
      if (k == rst_at) begin
        @(posedge sys_clk);
        #5 rst = 1;
        repeat (10) @(posedge sys_clk);
        #5 rst = 0;
      end
      line_sdata = k < CH ? ~v[k] : 1'($urandom_range(0, 1));
      #500 line_sclk = 1;
      #500 line_sclk = 0;
    end
    #500 line_sen = 0;
    line_sdata = 1;
    #3000;
  endtask
  initial begin
    int lens[8] = '{10, 20, 30, 47, 49, 50, 55, 60};
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) run[i] = 0;
    repeat (10) begin
      @(negedge sys_clk);
      chk("reset_valve_state", valve_state, 0);
      chk("reset_frame_err", frame_err, 0);
    end
    @(posedge sys_clk);
    #5 rst = 0;
    send(48'h8000_0001_0009, CH, -1);
    send(48'h8000_0001_0009, CH, -1);
    send(48'h0000_0000_0001, CH, -1);
    send(48'h0000_0000_ABCD, 47, -1);
    send(48'h0000_0000_1234, 50, -1);
    send(48'h0000_0000_0009, CH, -1);
    send(48'h0000_0000_0001, CH, -1);
    send(48'h0000_0000_0009, CH, -1);
    send(48'hFFFF_FFFF_FFFF, CH, 20);
    send(48'h5555_AAAA_1234, CH, -1);
    repeat (20) begin
      v = CH'({$urandom, $urandom});
      send(v, $urandom_range(0, 3) != 0 ? CH : lens[$urandom_range(0, 7)], -1);
    end
    v = 48'h8421_0000_F00F;
    send(v, CH, -1);
    repeat (5000) @(negedge sys_clk);
`ifdef VALVE_HOLD_TIMEOUT_EN
    chk("idle_timeout_state", valve_state, 0);
`else
    chk("idle_hold_state", valve_state, v);
`endif
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
